// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pio_pkg
//  Purpose  : Shared constants and state encoding for the PIO bus master.
//  Revision : 1.0  initial release
// ============================================================================
package pio_pkg;

    // PIO data/address word width
    localparam int PIO_NBITS = 32;

    // Read data returned when a read is abandoned
    localparam logic [PIO_NBITS-1:0] PIO_TIMEOUT_RDATA = 32'hFFFF_FFFF;

    // Default number of clk_div strobes before a transaction is abandoned
    localparam int PIO_TIMEOUT_DIVS_DFLT = 64;

    // Master FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RSP   = 3'd3,
        ST_DRAIN = 3'd4
    } pio_state_e;

endpackage : pio_pkg
`default_nettype wire

// File: rtl/pio_ack_mux.sv
`default_nettype none
// ============================================================================
//  Module   : pio_ack_mux
//  Purpose  : Picks the selected responder's acknowledge and read-data slice
//             out of the flat per-responder buses.
//  Revision : 1.0  initial release
// ============================================================================
module pio_ack_mux
    import pio_pkg::*;
#(
    parameter  int MS_NBITS = 2,
    localparam int N_MS     = 1 << MS_NBITS
) (
    input  logic [MS_NBITS-1:0]       sel_i,
    input  logic [N_MS-1:0]           mem_ack_i,
    input  logic [PIO_NBITS*N_MS-1:0] mem_rdata_i,
    output logic                      ack_o,
    output logic [PIO_NBITS-1:0]      rdata_o
);

    // Flat read-data bus viewed as one word per responder
    logic [PIO_NBITS-1:0] w_slice [N_MS];

    for (genvar gi = 0; gi < N_MS; gi++) begin : g_slice
        assign w_slice[gi] = mem_rdata_i[PIO_NBITS*gi +: PIO_NBITS];
    end

    assign ack_o   = mem_ack_i[sel_i];
    assign rdata_o = w_slice[sel_i];

endmodule : pio_ack_mux
`default_nettype wire

// File: rtl/pio_master.sv
`default_nettype none
// ============================================================================
//  Module   : pio_master
//  Purpose  : Single-outstanding PIO bus initiator. Converts a host command
//             into one strobed register/memory access toward a one-hot
//             selected responder, waits for its acknowledge (or a clk_div
//             paced timeout) and returns the completion to the host.
//  Revision : 1.0  initial release
// ============================================================================
module pio_master
    import pio_pkg::*;
#(
    parameter  int MS_NBITS     = 2,
    parameter  int MS_LSB       = 16,
    parameter  int TIMEOUT_DIVS = PIO_TIMEOUT_DIVS_DFLT,
    localparam int N_MS         = 1 << MS_NBITS
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clk_div,
    // host command side
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_wr,
    input  logic [31:0]               cmd_addr,
    input  logic [31:0]               cmd_wdata,
    // host completion side
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    // PIO responder fabric
    output logic [31:0]               reg_addr,
    output logic [31:0]               reg_din,
    output logic                      reg_rd,
    output logic                      reg_wr,
    output logic [N_MS-1:0]           reg_ms,
    input  logic [N_MS-1:0]           mem_ack,
    input  logic [PIO_NBITS*N_MS-1:0] mem_rdata,
    output logic                      busy
);

    // Counter wide enough to hold TIMEOUT_DIVS itself (it saturates there)
    localparam int               CNT_W   = (TIMEOUT_DIVS < 1) ? 1 : $clog2(TIMEOUT_DIVS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_DIVS);

    pio_state_e             state_q,     state_d;
    logic [31:0]            addr_q,      addr_d;
    logic [31:0]            wdata_q,     wdata_d;
    logic                   wr_q,        wr_d;
    logic [MS_NBITS-1:0]    sel_q,       sel_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic                   timed_out_q, timed_out_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q,   rsp_err_d;
    logic                   reg_rd_q,    reg_rd_d;
    logic                   reg_wr_q,    reg_wr_d;
    logic [N_MS-1:0]        reg_ms_q,    reg_ms_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   busy_q,      busy_d;

    logic                   w_ack_sel;
    logic [PIO_NBITS-1:0]   w_rdata_sel;
    logic                   w_expired;
    logic [CNT_W-1:0]       w_cnt_inc;

    // Only the latched responder's ack/data is ever looked at
    pio_ack_mux #(
        .MS_NBITS    (MS_NBITS)
    ) u_ack_mux (
        .sel_i       (sel_q),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .ack_o       (w_ack_sel),
        .rdata_o     (w_rdata_sel)
    );

    assign w_expired = (cnt_q >= CNT_MAX);
    assign w_cnt_inc = (clk_div && !w_expired) ? cnt_q + CNT_W'(1) : cnt_q;

    // Next-state and registered-output logic of the transaction FSM
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        reg_rd_d    = 1'b0;
        reg_wr_d    = 1'b0;
        reg_ms_d    = reg_ms_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d   = cmd_addr;
                    wdata_d  = cmd_wdata;
                    wr_d     = cmd_wr;
                    sel_d    = cmd_addr[MS_LSB +: MS_NBITS];
                    reg_rd_d = ~cmd_wr;
                    reg_wr_d = cmd_wr;
                    reg_ms_d = N_MS'(1) << cmd_addr[MS_LSB +: MS_NBITS];
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // An ack in the expiry cycle still wins
                if (w_ack_sel) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = wr_q ? '0 : w_rdata_sel;
                    timed_out_d = 1'b0;
                    reg_ms_d    = '0;
                    state_d     = ST_RSP;
                end else if (w_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = wr_q ? '0 : PIO_TIMEOUT_RDATA;
                    timed_out_d = 1'b1;
                    reg_ms_d    = '0;
                    state_d     = ST_RSP;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            ST_RSP: begin
                reg_ms_d = '0;
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    cnt_d       = '0;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A stuck ack must not complete the next command; after a
                // timeout the responder may never release it, so bound it.
                if (!w_ack_sel) begin
                    state_d = ST_IDLE;
                end else if (timed_out_q) begin
                    if (w_expired) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            sel_q       <= '0;
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_ms_q    <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            reg_rd_q    <= reg_rd_d;
            reg_wr_q    <= reg_wr_d;
            reg_ms_q    <= reg_ms_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign reg_addr  = addr_q;
    assign reg_din   = wdata_q;
    assign reg_rd    = reg_rd_q;
    assign reg_wr    = reg_wr_q;
    assign reg_ms    = reg_ms_q;
    assign busy      = busy_q;

endmodule : pio_master
`default_nettype wire

// File: doc/pio_master.md
# pio_master

PIO bus initiator that turns single host commands into PIO register/memory transactions toward the PIO-attached responders (memories, register blocks) and returns the completion. It drives address, write data, read/write strobes and one-hot module select, then waits for the selected responder's acknowledge. It captures read data, or reports a timeout. It sits between the host/CSR command path and the PIO responder fabric, in the `clk` domain, with bus pacing from `clk_div`.

## Interface
Parameters:
- `MS_NBITS`, default 2. Module-select index width; `N_MS = 1<<MS_NBITS` responders.
- `MS_LSB`, default 16. Lowest address bit of the module-select field, `cmd_addr[MS_LSB+MS_NBITS-1:MS_LSB]`.
- `TIMEOUT_DIVS`, default 64. Number of `clk_div` strobes in WAIT before the master abandons a transaction.

Ports:
- `clk`  in  1  sole clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `clk_div`  in  1  single-cycle PIO pacing strobe.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  master idle and able to accept a command.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  byte address.
- `cmd_wdata`  in  32  write data.
- `rsp_valid`  out  1  completion available.
- `rsp_ready`  in  1  host takes the completion.
- `rsp_rdata`  out  32  read data; 0 for writes; `32'hFFFF_FFFF` on timeout of a read.
- `rsp_err`  out  1  transaction timed out.
- `reg_addr`  out  32  PIO address.
- `reg_din`  out  32  PIO write data.
- `reg_rd`  out  1  read strobe, one `clk` cycle per transaction.
- `reg_wr`  out  1  write strobe, one `clk` cycle per transaction.
- `reg_ms`  out  N_MS  one-hot module select, held for the whole transaction.
- `mem_ack`  in  N_MS  per-responder acknowledge (level, held about one `clk_div` period).
- `mem_rdata`  in  32*N_MS  per-responder read data; slice i is `[32*i+31:32*i]`.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, REQ, WAIT, RSP, DRAIN.
- **IDLE:** `cmd_ready=1`. When `cmd_valid&cmd_ready`:
  - latch `cmd_addr`, `cmd_wdata` and `cmd_wr`;
  - latch select index `sel = cmd_addr[MS_LSB+MS_NBITS-1:MS_LSB]`;
  - go to REQ.
- **REQ (one cycle):**
  - `reg_ms[sel]=1`;
  - `reg_rd=~wr`, `reg_wr=wr`;
  - `reg_addr`/`reg_din` drive the latched values;
  - clear the timeout counter; go to WAIT.
- **WAIT:**
  - strobes are 0; `reg_ms`, `reg_addr` and `reg_din` are held stable;
  - the counter increments on each `clk_div`;
  - only `mem_ack[sel]` is observed; acks of other responders are ignored;
  - on `mem_ack[sel]=1`: capture `mem_rdata` slice `sel` (reads) or 0 (writes), set `rsp_err=0`, go to RSP;
  - else, when the counter reaches `TIMEOUT_DIVS`: set `rsp_err=1`, set `rsp_rdata` to all-ones (read) or 0 (write), go to RSP;
  - ack takes priority if it arrives in the same cycle as expiry.
- **RSP:** `rsp_valid=1`; `reg_ms=0`. When `rsp_ready`, go to DRAIN.
- **DRAIN:**
  - wait until `mem_ack[sel]=0`, then go to IDLE;
  - this prevents a held or late ack from completing the next command;
  - a DRAIN started after a timeout is also bounded by `TIMEOUT_DIVS` strobes, then the master goes to IDLE.
- Only one outstanding transaction at a time; no pipelining.

## Timing
- Reset values:
  - `reg_addr=0`, `reg_din=0`, `reg_rd=0`, `reg_wr=0`, `reg_ms=0`;
  - `cmd_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `busy=0`;
  - state = IDLE, counter = 0.
- All outputs are registered.
- Command accepted at cycle T:
  - strobe and `reg_ms` are high in cycle T+1;
  - WAIT starts at T+2.
- Ack first sampled high in cycle A:
  - `rsp_valid`, `rsp_rdata` and `rsp_err` are valid from A+1;
  - `reg_ms` is 0 from A+1.
- `rsp_*` are held until the cycle with `rsp_valid&rsp_ready`; they deassert the next cycle.
- Minimum command-to-command spacing is 4 cycles plus ack-drop time.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously). No response is produced; the next command after reset is handled normally.
- The counter saturates at `TIMEOUT_DIVS`; no wrap-around.

## Structure
- Shared package `pio_pkg`:
  - `PIO_NBITS=32`;
  - state encoding constants;
  - `PIO_TIMEOUT_RDATA=32'hFFFF_FFFF`;
  - default `TIMEOUT_DIVS`.
- Sub-module `pio_ack_mux`: parameterised by `MS_NBITS`; selects `mem_ack[sel]` and the `mem_rdata` slice. The FSM and the counter stay in the top level.

## Test plan
- Write to `cmd_addr=32'h0001_0040`, data `32'h1234_5678`:
  - `reg_ms=4'b0010`, `reg_wr` is a one-cycle pulse, `reg_addr=32'h0001_0040`;
  - responder acks after 3 `clk_div` strobes;
  - `rsp_valid` one cycle after the ack, with `rsp_err=0`, `rsp_rdata=0`.
- Read `cmd_addr=32'h0003_0008`, responder 3 returns `32'hCAFE_F00D`:
  - `rsp_rdata=32'hCAFE_F00D`;
  - `reg_rd` high for exactly one cycle.
- No ack, `TIMEOUT_DIVS=4`, read:
  - after 4 `clk_div` strobes, `rsp_err=1` and `rsp_rdata=32'hFFFF_FFFF`;
  - a late ack during DRAIN causes no second response.
- `mem_ack[0]` pulses while `sel=2`:
  - ignored; the transaction completes only on `mem_ack[2]`.
- Back-to-back commands with `rsp_ready` held 0 for 5 cycles, and `mem_ack` held high for 2 cycles after RSP:
  - `cmd_ready` stays 0 until the ack drops;
  - the second command issues correctly.
- `rstn` asserted during WAIT:
  - all outputs reach reset values in the same cycle;
  - no `rsp_valid`;
  - a new read after reset completes normally.
